rd_frame_reader: RTL and testbench

RD_FRAME_READER -- requirements
Module: rd_frame_reader

---
 rtl/sdram_stream_pkg.sv | 16 +
 rtl/rd_skid_buf.sv | 64 ++++++
 rtl/rd_frame_reader.sv | 152 +++++++++++++++
 tb/tb_rd_frame_reader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_stream_pkg.sv
// Shared types and default geometry for the SDRAM frame streaming blocks.
package sdram_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_FILL   = 2'd2,
    ST_STREAM = 2'd3
  } rd_state_t;

  localparam int DEF_H_PIXELS     = 640;
  localparam int DEF_V_LINES      = 480;
  localparam int DEF_PREFETCH_TH  = 256;
  localparam int DEF_FLUSH_CYCLES = 16;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer between the read-FIFO return path and the pixel stream.
module rd_skid_buf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] head_p0;
  logic [DATA_W-1:0] tail_p0;
  logic [1:0]        cnt;
  logic              pop;

  assign pop       = out_valid && out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = head_p0;
  assign in_ready  = (cnt != 2'd2);
  assign occupancy = cnt;

  // head_p0 is always the presented word, so it holds steady while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 2'd0;
      head_p0 <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      unique case (cnt)
        2'd0: begin
          if (in_valid) begin
            head_p0 <= in_data;
            cnt     <= 2'd1;
          end
        end
        2'd1: begin
          if (in_valid && pop) begin
            head_p0 <= in_data;
          end else if (in_valid) begin
            tail_p0 <= in_data;
            cnt     <= 2'd2;
          end else if (pop) begin
            cnt <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_p0 <= tail_p0;
            if (in_valid) tail_p0 <= in_data;
            else          cnt     <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/rd_frame_reader.sv
// Streams one frame of 16-bit pixels out of the SDRAM read FIFO with a 2-word output buffer.
// Optional RD_FRAME_UNDERFLOW_CNT_EN adds a saturating count of starvation clocks.
module rd_frame_reader
  import sdram_stream_pkg::*;
#(
  parameter int H_PIXELS     = DEF_H_PIXELS,
  parameter int V_LINES      = DEF_V_LINES,
  parameter int PREFETCH_TH  = DEF_PREFETCH_TH,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [9:0]  rd_fifo_cnt,
  input  logic [15:0] fifo_rd_data,
  output logic        fifo_rd_req,
  output logic        rd_rst,
  output logic        sdram_rd_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sof,
  output logic        out_eol,
  output logic        busy,
  output logic        underflow
`ifdef RD_FRAME_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] underflow_cnt
`endif
);

  localparam int TOTAL_WORDS = H_PIXELS * V_LINES;
  localparam int PIX_W  = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int LINE_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int ISS_W  = $clog2(TOTAL_WORDS + 1);
  localparam int FL_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [ISS_W-1:0]  TOTAL_ISS = ISS_W'(TOTAL_WORDS);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(H_PIXELS - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES - 1);
  localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [9:0]        PF_TH     = 10'(PREFETCH_TH);

  rd_state_t         state;
  logic [FL_W-1:0]   flush_cnt;
  logic [ISS_W-1:0]  issued;
  logic [PIX_W-1:0]  pix;
  logic [LINE_W-1:0] line;
  logic              rd_vld_p1;
  logic [1:0]        buf_occ;
  logic              buf_in_ready;
  logic              accept;
  logic              last_word;
  logic              buf_room;
  logic              starve;

`ifdef RD_FRAME_UNDERFLOW_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign accept    = out_valid && out_ready;
  assign last_word = (pix == PIX_LAST) && (line == LINE_LAST);
  // Pop-side space is ignored on purpose: occupancy plus the word in flight never exceeds two.
  assign buf_room  = buf_in_ready && (({1'b0, buf_occ} + {2'b0, rd_vld_p1}) < 3'd2);
  assign starve    = (state == ST_STREAM) && (rd_fifo_cnt == 10'd0) && !out_valid;

  // p0: issue a FIFO pop; the FIFO's count has not yet seen last cycle's pop
  assign fifo_rd_req = !rst && !frame_start && (state == ST_STREAM) &&
                       (issued < TOTAL_ISS) &&
                       (rd_fifo_cnt > {9'b0, rd_vld_p1}) && buf_room;

  assign rd_rst         = (state == ST_FLUSH);
  assign sdram_rd_valid = (state == ST_FILL) || (state == ST_STREAM);
  assign busy           = (state != ST_IDLE);
  assign out_sof        = out_valid && (pix == '0) && (line == '0);
  assign out_eol        = out_valid && (pix == PIX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      issued    <= '0;
      pix       <= '0;
      line      <= '0;
      rd_vld_p1 <= 1'b0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      state     <= ST_FLUSH;
      flush_cnt <= '0;
      issued    <= '0;
      pix       <= '0;
      line      <= '0;
      rd_vld_p1 <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_vld_p1 <= fifo_rd_req;
      if (fifo_rd_req) issued <= issued + 1'b1;
      if (accept) begin
        if (pix == PIX_LAST) begin
          pix  <= '0;
          line <= (line == LINE_LAST) ? '0 : line + 1'b1;
        end else begin
          pix <= pix + 1'b1;
        end
      end
      if (starve) underflow <= 1'b1;
      unique case (state)
        ST_IDLE: ;
        ST_FLUSH: begin
          if (flush_cnt == FL_LAST) begin
            state     <= ST_FILL;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        ST_FILL: begin
          if (rd_fifo_cnt >= PF_TH) state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (accept && last_word) state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RD_FRAME_UNDERFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || frame_start) underflow_cnt <= 16'd0;
    else if (starve)        underflow_cnt <= sat_inc16(underflow_cnt);
  end
`endif

  // p1: word returned by the FIFO lands in the output buffer
  rd_skid_buf #(
    .DATA_W(16)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (frame_start),
    .in_valid  (rd_vld_p1),
    .in_data   (fifo_rd_data),
    .in_ready  (buf_in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (buf_occ)
  );

endmodule

// File: tb/tb_rd_frame_reader.sv
// Randomized bench for rd_frame_reader: FIFO model, frame-level reference and scoreboard.
module tb_rd_frame_reader;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int TH    = 8;
  localparam int FL    = 16;
  localparam int TOTAL = H * V;
  localparam int MEM_N = 8192;
  localparam int P_IDLE = 0, P_FLUSH = 1, P_FILL = 2, P_STREAM = 3;

  logic        clk = 1'b0;
  logic        rst, frame_start, out_ready;
  logic [9:0]  rd_fifo_cnt;
  logic [15:0] fifo_rd_data;
  logic        fifo_rd_req, rd_rst, sdram_rd_valid, out_valid, out_sof, out_eol, busy, underflow;
  logic [15:0] out_data;
`ifdef RD_FRAME_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  always #5 clk = ~clk;

  rd_frame_reader #(
    .H_PIXELS(H), .V_LINES(V), .PREFETCH_TH(TH), .FLUSH_CYCLES(FL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .rd_fifo_cnt    (rd_fifo_cnt),
    .fifo_rd_data   (fifo_rd_data),
    .fifo_rd_req    (fifo_rd_req),
    .rd_rst         (rd_rst),
    .sdram_rd_valid (sdram_rd_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sof        (out_sof),
    .out_eol        (out_eol),
    .busy           (busy),
    .underflow      (underflow)
`ifdef RD_FRAME_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt  (underflow_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // read-FIFO model: words mem[rd_ptr..wr_ptr-1] are resident
  logic [15:0] mem [MEM_N];
  int rd_ptr = 0, wr_ptr = 0;
  int fill_lim = 0, fill_pct = 0, ready_pct = 100;
  bit force_zero = 0, refill_ok = 0;
  bit inflight = 0, next_inflight = 0;
  logic [15:0] pend_word = '0;

  // frame-level reference
  logic [15:0] exp_q[$];
  int ph = P_IDLE, fl_cnt = 0, issued = 0, acc_idx = 0, ucnt = 0, frames_done = 0;
  bit uf = 0, model_en = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_cnt();
    int avail;
    avail = wr_ptr - rd_ptr;
    rd_fifo_cnt = force_zero ? 10'd0 : ((avail > 1023) ? 10'd1023 : 10'(avail));
  endtask

  // Evaluate the cycle that ends at the coming edge and advance the reference.
  task automatic observe();
    int occ;
    bit acc, req_ok;
    occ = exp_q.size() - int'(inflight);
    acc = (out_valid === 1'b1) && (out_ready === 1'b1);
    refill_ok = (sdram_rd_valid === 1'b1);
    if (model_en && !rst) begin
      check("rd_rst", {31'b0, rd_rst}, {31'b0, ph == P_FLUSH});
      check("sdram_rd_valid", {31'b0, sdram_rd_valid}, {31'b0, (ph == P_FILL) || (ph == P_STREAM)});
      check("busy", {31'b0, busy}, {31'b0, ph != P_IDLE});
      check("underflow", {31'b0, underflow}, {31'b0, uf});
`ifdef RD_FRAME_UNDERFLOW_CNT_EN
      check("underflow_cnt", {16'b0, underflow_cnt}, 32'(ucnt));
`endif
      check("out_valid", {31'b0, out_valid}, {31'b0, occ > 0});
      if (!frame_start) begin
        req_ok = (ph == P_STREAM) && (issued < TOTAL) &&
                 (int'(rd_fifo_cnt) > int'(inflight)) && (exp_q.size() < 2);
        check("fifo_rd_req", {31'b0, fifo_rd_req}, {31'b0, req_ok});
      end
    end
    next_inflight = 1'b0;
    if (rst || frame_start) begin
      ph = rst ? P_IDLE : P_FLUSH;
      fl_cnt = 0; issued = 0; acc_idx = 0; uf = 0; ucnt = 0;
      exp_q.delete();
    end else begin
      if (ph == P_STREAM && rd_fifo_cnt == 10'd0 && occ == 0) begin
        uf = 1'b1;
        if (ucnt < 65535) ucnt++;
      end
      if (acc && exp_q.size() > 0) begin
        check("out_data", {16'b0, out_data}, {16'b0, exp_q[0]});
        check("out_sof", {31'b0, out_sof}, {31'b0, acc_idx == 0});
        check("out_eol", {31'b0, out_eol}, {31'b0, (acc_idx % H) == H - 1});
        void'(exp_q.pop_front());
        acc_idx++;
      end
      if (fifo_rd_req === 1'b1) begin
        check("pop_nonempty", {31'b0, wr_ptr > rd_ptr}, 32'd1);
        pend_word = mem[rd_ptr % MEM_N];
        rd_ptr++;
        exp_q.push_back(pend_word);
        issued++;
        next_inflight = 1'b1;
      end
      case (ph)
        P_FLUSH: begin
          fl_cnt++;
          if (fl_cnt == FL) ph = P_FILL;
        end
        P_FILL:   if (int'(rd_fifo_cnt) >= TH) ph = P_STREAM;
        P_STREAM: if (acc && acc_idx == TOTAL) begin ph = P_IDLE; frames_done++; end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    #1;
    observe();
    @(posedge clk);
    #1;
    inflight = next_inflight;
    fifo_rd_data = inflight ? pend_word : 16'($urandom);
    if (refill_ok && (wr_ptr - rd_ptr) < fill_lim && $urandom_range(99) < fill_pct) wr_ptr++;
    out_ready = ($urandom_range(99) < ready_pct);
    set_cnt();
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic run_to_acc(input int target);
    int n;
    n = 0;
    while (acc_idx < target && n < 4000) begin tick(); n++; end
    if (n >= 4000) check("timeout_acc", 32'(acc_idx), 32'(target));
  endtask

  task automatic run_to_idle();
    int n, f0;
    n = 0;
    f0 = frames_done;
    while (busy === 1'b1 && n < 4000) begin tick(); n++; end
    check("frame_idle", {31'b0, busy}, 32'd0);
    check("frame_done", 32'(frames_done - f0), 32'd1);
    check("frame_leftover", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
    rst = 1'b1; frame_start = 1'b0; out_ready = 1'b0;
    fifo_rd_data = '0;
    set_cnt();

    // reset values
    repeat (3) tick();
    check("rst_fifo_rd_req", {31'b0, fifo_rd_req}, 32'd0);
    check("rst_rd_rst", {31'b0, rd_rst}, 32'd0);
    check("rst_sdram_rd_valid", {31'b0, sdram_rd_valid}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {16'b0, out_data}, 32'd0);
    check("rst_sof_eol", {30'b0, out_sof, out_eol}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_underflow", {31'b0, underflow}, 32'd0);
    rst = 1'b0;
    model_en = 1'b1;
    tick();

    // flush length and prefetch start with 300 words resident, full-rate sink
    wr_ptr = 300; fill_lim = 300; fill_pct = 100; ready_pct = 100;
    set_cnt();
    start_frame();
    check("flush_no_refill", {31'b0, sdram_rd_valid}, 32'd0);
    n = 0;
    while (rd_rst === 1'b1 && n < 40) begin tick(); n++; end
    check("flush_len", 32'(n), 32'(FL));
    check("fill_refill", {31'b0, sdram_rd_valid}, 32'd1);
    check("fill_no_req", {31'b0, fifo_rd_req}, 32'd0);
    tick();
    check("stream_req", {31'b0, fifo_rd_req}, 32'd1);
    run_to_idle();

    // 30% sink duty with a slow, shallow refill
    fill_lim = 64; fill_pct = 70; ready_pct = 30;
    start_frame();
    run_to_idle();

    // starvation mid-line, then recovery
    fill_lim = 300; fill_pct = 100; ready_pct = 100;
    start_frame();
    run_to_acc(37);
    check("uf_before", {31'b0, underflow}, 32'd0);
    force_zero = 1'b1;
    set_cnt();
    repeat (12) begin
      tick();
      check("starved_req", {31'b0, fifo_rd_req}, 32'd0);
    end
    check("uf_set", {31'b0, underflow}, 32'd1);
    force_zero = 1'b0;
    set_cnt();
    repeat (5) tick();
    check("uf_sticky", {31'b0, underflow}, 32'd1);
    run_to_idle();

    // restart in the middle of a frame
    ready_pct = 60;
    start_frame();
    run_to_acc(100);
    start_frame();
    check("restart_flush", {31'b0, rd_rst}, 32'd1);
    check("restart_empty", {31'b0, out_valid}, 32'd0);
    run_to_idle();

    // reset mid-stream discards everything in flight
    ready_pct = 50;
    start_frame();
    run_to_acc(20);
    rst = 1'b1;
    tick();
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_req", {31'b0, fifo_rd_req}, 32'd0);
    check("midrst_underflow", {31'b0, underflow}, 32'd0);
    rst = 1'b0;
    tick();
    start_frame();
    run_to_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
